// File: rtl/ram8_seq.sv
// rtl/ram8_seq.sv - 8-entry register file fed by a demuxed load, with a sequenced clear engine
// Optional RAM8_SEQ_REGOUT_EN registers the read port (one-cycle read latency).
module ram8_seq #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             clear_req,
  output logic [WIDTH-1:0] out,
  output logic [7:0]       load_sel,
  output logic             busy,
  output logic             clear_done
);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t           state;
  logic [2:0]       counter;
  logic [WIDTH-1:0] regs [8];

  // Exactly one-hot or zero: the clear walk owns the write port while busy.
  always_comb begin
    load_sel = '0;
    if (!reset) begin
      case (state)
        IDLE:    if (load) load_sel = 8'b1 << address;
        CLEAR:   load_sel = 8'b1 << counter;
        default: load_sel = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (load_sel[i]) regs[i] <= (state == CLEAR) ? CLEAR_VAL : in;
      end
      case (state)
        IDLE: begin
          counter <= '0;
          if (clear_req) state <= CLEAR;
        end
        CLEAR: begin
          counter <= counter + 3'd1;
          if (counter == 3'd7) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign clear_done = (state == DONE);

`ifdef RAM8_SEQ_REGOUT_EN
  always_ff @(posedge clock) begin
    if (reset) out <= '0;
    else       out <= regs[address];
  end
`else
  assign out = regs[address];
`endif

endmodule

// File: tb/tb_ram8_seq.sv
// tb/tb_ram8_seq.sv - directed scoreboard bench for ram8_seq
module tb_ram8_seq;

  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic [2:0]       address;
  logic             load;
  logic             clear_req;
  logic [WIDTH-1:0] out;
  logic [7:0]       load_sel;
  logic             busy;
  logic             clear_done;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model [8];
  logic [WIDTH-1:0] exp_q [$];

  ram8_seq #(.WIDTH(WIDTH), .CLEAR_VAL('0)) dut (
    .clock(clock), .reset(reset), .in(in), .address(address), .load(load),
    .clear_req(clear_req), .out(out), .load_sel(load_sel), .busy(busy),
    .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reads go through the scoreboard: expected pushed on drive, popped on sample.
  task automatic read_chk(input int a);
    logic [WIDTH-1:0] e;
    cyc();
    load    = 1'b0;
    address = 3'(a);
    exp_q.push_back(model[a]);
`ifdef RAM8_SEQ_REGOUT_EN
    cyc();
`endif
    settle();
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("read_addr%0d", a), 32'(out), 32'(e));
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 8; a++) read_chk(a);
  endtask

  task automatic write(input int a, input logic [WIDTH-1:0] d);
    cyc();
    load    = 1'b1;
    address = 3'(a);
    in      = d;
    settle();
    chk($sformatf("write_sel%0d", a), 32'(load_sel), 32'(8'b1 << a));
    model[a] = d;
  endtask

  // Assumes the next edge enters CLEAR with counter 0.
  task automatic clear_walk(input bit hold_req, input bit load_mid);
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0 && !hold_req) clear_req = 1'b0;
      if (k == 0) load = 1'b0;
      if (k == 2 && load_mid) begin
        load    = 1'b1;
        address = 3'd2;
        in      = 16'h1234;
      end
      settle();
      chk($sformatf("clr_busy%0d", k), 32'(busy), 32'd1);
      chk($sformatf("clr_sel%0d", k), 32'(load_sel), 32'(8'b1 << k));
      chk($sformatf("clr_done_low%0d", k), 32'(clear_done), 32'd0);
    end
    cyc();
    settle();
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_pulse", 32'(clear_done), 32'd1);
    chk("done_sel", 32'(load_sel), 32'd0);
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  initial begin
    reset = 1'b1; in = '0; address = '0; load = 1'b1; clear_req = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    settle();
    chk("reset_sel", 32'(load_sel), 32'd0);
    cyc();
    reset = 1'b0; load = 1'b0;
    settle();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(clear_done), 32'd0);
    chk("idle_sel", 32'(load_sel), 32'd0);
    read_all();

    // Single demuxed write
    write(5, 16'hBEEF);
`ifndef RAM8_SEQ_REGOUT_EN
    chk("write_old_data", 32'(out), 32'd0);
`endif
    read_all();

    // Fill then clear
    for (int i = 0; i < 8; i++) write(i, 16'(i * 16'h1111));
    cyc();
    load = 1'b0; clear_req = 1'b1;
    settle();
    chk("pre_clear_busy", 32'(busy), 32'd0);
    clear_walk(1'b0, 1'b0);
    cyc();
    settle();
    chk("post_clear_busy", 32'(busy), 32'd0);
    chk("post_clear_done", 32'(clear_done), 32'd0);
    read_all();

    // External load arriving during the clear is ignored
    write(2, 16'h5555);
    cyc();
    load = 1'b0; clear_req = 1'b1;
    clear_walk(1'b0, 1'b1);
    cyc();
    load = 1'b0;
    settle();
    chk("load_mid_busy", 32'(busy), 32'd0);
    read_all();

    // Load and clear_req together, clear_req held for a back-to-back sequence
    cyc();
    load = 1'b1; address = 3'd7; in = 16'hAAAA; clear_req = 1'b1;
    settle();
    chk("simul_sel", 32'(load_sel), 32'h80);
    clear_walk(1'b1, 1'b0);
    cyc();
    settle();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    cyc();
    clear_req = 1'b0;
    settle();
    chk("b2b_restart_busy", 32'(busy), 32'd1);
    chk("b2b_restart_sel", 32'(load_sel), 32'h01);
    for (int k = 1; k < 8; k++) cyc();
    cyc();
    settle();
    chk("b2b_done", 32'(clear_done), 32'd1);
    read_all();

    // Reset during the 4th CLEAR cycle aborts the walk with no completion pulse
    for (int i = 0; i < 8; i++) write(i, 16'hF0F0 ^ 16'(i));
    cyc();
    load = 1'b0; clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    settle();
    chk("midreset_sel", 32'(load_sel), 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    settle();
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(clear_done), 32'd0);
    for (int k = 0; k < 10; k++) begin
      cyc();
      settle();
      chk($sformatf("midreset_no_pulse%0d", k), 32'(clear_done), 32'd0);
    end
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
